// File: rtl/lcd_frame_writer.sv
// 8080-style LCD frame writer: window setup commands, then one
// RGB565 word per pixel from an upstream coordinate counter.
module lcd_frame_writer #(
    parameter int X_COUNT = 320,
    parameter int Y_COUNT = 240,
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] pixel_color,
    output logic        counter_clr,
    output logic        pixel_inc,
    output logic        busy,
    output logic        frame_done,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic [15:0] lcd_data
);

    localparam int PH = WR_LOW + WR_HIGH;
    localparam int PW = $clog2(PH + 1);
    localparam logic [PW-1:0] LAST = PW'(PH - 1);
    localparam logic [PW-1:0] PRE  = PW'(PH - 2);
    localparam logic [PW-1:0] LOW  = PW'(WR_LOW);
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [16:0] NLAST = 17'(X_COUNT * Y_COUNT - 1);
    localparam logic [15:0] XM = 16'(X_COUNT - 1);
    localparam logic [15:0] YM = 16'(Y_COUNT - 1);

    typedef enum logic [1:0] {IDLE, CMD, PIXEL, DONE} state_t;

    state_t        state;
    logic [PW-1:0] phase;
    logic [3:0]    step;
    logic [16:0]   count;
    logic [15:0]   pix_q;
    logic [15:0]   cmd_word;
    logic          cmd_rs;

    always_comb begin
        cmd_word = '0;
        cmd_rs   = 1'b1;
        case (step)
            4'd0:    begin cmd_word = 16'h002A; cmd_rs = 1'b0; end
            4'd3:    cmd_word = {8'h00, XM[15:8]};
            4'd4:    cmd_word = {8'h00, XM[7:0]};
            4'd5:    begin cmd_word = 16'h002B; cmd_rs = 1'b0; end
            4'd8:    cmd_word = {8'h00, YM[15:8]};
            4'd9:    cmd_word = {8'h00, YM[7:0]};
            4'd10:   begin cmd_word = 16'h002C; cmd_rs = 1'b0; end
            default: cmd_word = '0;
        endcase
    end

    // Bus pins decode straight from registered state so reset clears them at once.
    // The first pixel cycle drives the live colour; later cycles show the capture.
    always_comb begin
        lcd_wr_n = 1'b1;
        lcd_rs   = 1'b1;
        lcd_data = '0;
        if (state == CMD) begin
            lcd_wr_n = !(phase < LOW);
            lcd_rs   = cmd_rs;
            lcd_data = cmd_word;
        end else if (state == PIXEL) begin
            lcd_wr_n = !(phase < LOW);
            lcd_data = (phase == '0) ? pixel_color : pix_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            step        <= '0;
            count       <= '0;
            pix_q       <= '0;
            busy        <= 1'b0;
            lcd_cs_n    <= 1'b1;
            counter_clr <= 1'b0;
            pixel_inc   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            counter_clr <= 1'b0;
            pixel_inc   <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= CMD;
                        busy        <= 1'b1;
                        lcd_cs_n    <= 1'b0;
                        counter_clr <= 1'b1;
                        step        <= '0;
                        phase       <= '0;
                    end
                end
                CMD: begin
                    if (phase == LAST) begin
                        phase <= '0;
                        if (step == 4'd10) begin
                            state <= PIXEL;
                            step  <= '0;
                            count <= '0;
                        end else begin
                            step <= step + 4'd1;
                        end
                    end else begin
                        phase <= phase + ONE;
                    end
                end
                PIXEL: begin
                    if (phase == '0) pix_q <= pixel_color;
                    pixel_inc <= (phase == PRE);
                    if (phase == LAST) begin
                        phase <= '0;
                        if (count == NLAST) begin
                            state      <= DONE;
                            count      <= '0;
                            busy       <= 1'b0;
                            lcd_cs_n   <= 1'b1;
                            frame_done <= 1'b1;
                        end else begin
                            count <= count + 17'd1;
                        end
                    end else begin
                        phase <= phase + ONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Scoreboard bench for lcd_frame_writer: random colours, re-pulsed
// and held start, mid-frame reset, strobe timing and frame length.
module tb_lcd_frame_writer;

    localparam int X = 5;
    localparam int Y = 3;
    localparam int L = 3;
    localparam int H = 2;
    localparam int N = X * Y;
    localparam int FLEN = (11 + N) * (L + H) + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pixel_color;
    logic        counter_clr, pixel_inc, busy, frame_done;
    logic        lcd_cs_n, lcd_rs, lcd_wr_n;
    logic [15:0] lcd_data;

    lcd_frame_writer #(
        .X_COUNT(X), .Y_COUNT(Y), .WR_LOW(L), .WR_HIGH(H)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pixel_color(pixel_color),
        .counter_clr(counter_clr), .pixel_inc(pixel_inc),
        .busy(busy), .frame_done(frame_done),
        .lcd_cs_n(lcd_cs_n), .lcd_rs(lcd_rs),
        .lcd_wr_n(lcd_wr_n), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [16:0] exp_q[$];
    logic [15:0] seed_q[$];
    logic [15:0] cur_seed = 16'h0;
    logic [16:0] cnt = 17'h0;

    // Upstream renderer: colour is a function of the coordinate counter.
    assign pixel_color = cur_seed + 16'(cnt) * 16'h0123;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (counter_clr) begin
            cnt <= '0;
            if (seed_q.size() > 0) cur_seed <= seed_q.pop_front();
        end else if (pixel_inc) begin
            cnt <= cnt + 17'd1;
        end
    end

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_frame();
        logic [15:0] seed;
        logic [15:0] xm;
        logic [15:0] ym;
        seed = 16'($urandom);
        xm = 16'(X - 1);
        ym = 16'(Y - 1);
        seed_q.push_back(seed);
        exp_q.push_back({1'b0, 16'h002A});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b1, 8'h00, xm[15:8]});
        exp_q.push_back({1'b1, 8'h00, xm[7:0]});
        exp_q.push_back({1'b0, 16'h002B});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b1, 16'h0000});
        exp_q.push_back({1'b1, 8'h00, ym[15:8]});
        exp_q.push_back({1'b1, 8'h00, ym[7:0]});
        exp_q.push_back({1'b0, 16'h002C});
        for (int i = 0; i < N; i++)
            exp_q.push_back({1'b1, 16'(seed + 16'(i) * 16'h0123)});
    endtask

    // Monitor: strobe widths, word stability, scoreboard pops, frame totals.
    int   cyc = 0;
    int   low_len = 0;
    int   high_len = 0;
    int   words = 0;
    int   incs = 0;
    int   clrs = 0;
    int   accept = 0;
    logic prev_wr = 1'b1;
    logic prev_busy = 1'b0;
    logic high_ok = 1'b0;
    logic [16:0] word = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_wr = 1'b1;
            prev_busy = 1'b0;
            high_ok = 1'b0;
            low_len = 0;
            high_len = 0;
            words = 0;
            incs = 0;
            clrs = 0;
        end else begin
            if (busy && !prev_busy) accept = cyc - 1;
            if (counter_clr) clrs++;
            if (!lcd_wr_n) begin
                if (prev_wr) begin
                    if (high_ok) chk("high_phase", high_len, H);
                    low_len = 1;
                    word = {lcd_rs, lcd_data};
                end else begin
                    low_len++;
                    chk("stable_low", {lcd_rs, lcd_data}, word);
                end
            end else if (!prev_wr) begin
                chk("low_phase", low_len, L);
                chk("stable_rise", {lcd_rs, lcd_data}, word);
                high_len = 1;
                high_ok = 1'b1;
                words++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL extra_word: got %0h expected none",
                             {lcd_rs, lcd_data});
                end else begin
                    chk("bus_word", {lcd_rs, lcd_data}, exp_q.pop_front());
                end
            end else if (!lcd_cs_n) begin
                high_len++;
                chk("stable_high", {lcd_rs, lcd_data}, word);
            end
            if (pixel_inc) begin
                incs++;
                chk("inc_pos", {lcd_wr_n, high_len == H, words > 11},
                    3'b111);
            end
            if (frame_done) begin
                chk("frame_len", cyc - accept + 1, FLEN);
                chk("last_high", high_len, H);
                chk("words", words, 11 + N);
                chk("incs", incs, N);
                chk("clrs", clrs, 1);
                chk("busy_done", busy, 0);
                chk("cs_done", lcd_cs_n, 1);
                words = 0;
                incs = 0;
                clrs = 0;
                high_ok = 1'b0;
            end
            prev_wr = lcd_wr_n;
            prev_busy = busy;
        end
    end

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2 * FLEN; c++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_inc"}, pixel_inc, 0);
        chk({tag, "_clr"}, counter_clr, 0);
        chk({tag, "_cs"}, lcd_cs_n, 1);
        chk({tag, "_wr"}, lcd_wr_n, 1);
        chk({tag, "_rs"}, lcd_rs, 1);
        chk({tag, "_data"}, lcd_data, 0);
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frames; odd ones see start re-pulsed while busy.
        for (int f = 0; f < 4; f++) begin
            push_frame();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < FLEN - 20; c++) begin
                @(negedge clk);
                start = f[0] && ($urandom_range(0, 3) == 0);
            end
            start = 1'b0;
            wait_done(ok);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        // Held start: back-to-back frames with one idle cycle.
        push_frame();
        push_frame();
        start = 1'b1;
        wait_done(ok);
        @(negedge clk);
        chk("gap_idle", busy, 0);
        @(negedge clk);
        chk("b2b_busy", busy, 1);
        wait_done(ok);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset inside the third pixel word.
        push_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 2 * FLEN; c++) begin
            @(negedge clk);
            if (incs == 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("inc_timeout", 0, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outs("mid");
        exp_q.delete();
        seed_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        push_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
